// File: rtl/oam_dma_sink.sv
// OAM-side responder for the sprite DMA: two-stage DMA write pipeline, CPU/PPU arbitration, status.
// Optional build macro OAM_DMA_SEQ_CHECK_EN adds the in-order DMA index checker driving seq_err.
module oam_dma_sink (
    input  logic        clk1,
    input  logic        reset,
    input  logic        dma_run,
    input  logic        dma_wr_stb,
    input  logic [7:0]  dma_a,
    input  logic [7:0]  dma_d,
    input  logic        cpu_oam_sel,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_a,
    input  logic [7:0]  cpu_d_in,
    output logic [7:0]  cpu_d_out,
    input  logic        ppu_rd,
    input  logic [7:0]  ppu_a,
    output logic [15:0] ppu_d,
    output logic        dma_done,
    output logic [7:0]  byte_cnt,
    output logic        addr_err,
    output logic        seq_err
);
    localparam logic [7:0] OAM_DEPTH = 8'd160;

    logic [7:0]  oam [0:159];
    logic        run_q;
    logic        run_rise;
    logic        busy;
    logic [7:0]  cnt_eff;
    logic        stb_acc;
    logic        stb_ok;
    logic        stb_bad;
    logic        vld_p0;
    logic [7:0]  a_p0;
    logic [7:0]  d_p0;
    logic        cpu_vld_p0;
    logic [7:0]  cpu_dat_p0;
    logic        ppu_vld_p0;
    logic [15:0] ppu_dat_p0;
    logic [7:0]  ppu_lo;
    logic [7:0]  ppu_hi;
    logic        cpu_wr_ok;

    assign run_rise  = dma_run & ~run_q;
    assign busy      = dma_run | vld_p0;
    // Expected index of an incoming byte: committed count plus the one still pending.
    assign cnt_eff   = run_rise ? 8'd0 : byte_cnt + {7'd0, vld_p0};
    assign stb_acc   = dma_wr_stb & dma_run;
    assign stb_ok    = stb_acc & (dma_a < OAM_DEPTH) & (cnt_eff != OAM_DEPTH);
    assign stb_bad   = stb_acc & ~stb_ok;
    assign ppu_lo    = {ppu_a[7:1], 1'b0};
    assign ppu_hi    = {ppu_a[7:1], 1'b1};
    assign cpu_wr_ok = cpu_oam_sel & cpu_wr & ~busy & (cpu_a < OAM_DEPTH);

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            run_q      <= 1'b0;
            vld_p0     <= 1'b0;
            byte_cnt   <= 8'd0;
            dma_done   <= 1'b0;
            addr_err   <= 1'b0;
            cpu_vld_p0 <= 1'b0;
            ppu_vld_p0 <= 1'b0;
            cpu_d_out  <= 8'hFF;
            ppu_d      <= 16'hFFFF;
        end else begin
            run_q      <= dma_run;
            vld_p0     <= stb_ok;
            byte_cnt   <= run_rise ? 8'd0 : byte_cnt + {7'd0, vld_p0};
            dma_done   <= vld_p0 & ~run_rise & dma_run & (byte_cnt == OAM_DEPTH - 8'd1);
            addr_err   <= stb_bad | (addr_err & ~run_rise);
            cpu_vld_p0 <= cpu_oam_sel & cpu_rd;
            ppu_vld_p0 <= ppu_rd;
            // Stage 1: present read data captured one edge earlier
            if (cpu_vld_p0)
                cpu_d_out <= cpu_dat_p0;
            if (ppu_vld_p0)
                ppu_d <= ppu_dat_p0;
        end
    end

    // Stage 0: capture pending DMA byte and snapshot read data (pre-write array contents)
    always_ff @(posedge clk1) begin
        a_p0       <= dma_a;
        d_p0       <= dma_d;
        cpu_dat_p0 <= busy ? 8'hFF : ((cpu_a >= OAM_DEPTH) ? 8'h00 : oam[cpu_a]);
        ppu_dat_p0 <= busy ? 16'hFFFF :
                      ((ppu_a >= OAM_DEPTH) ? 16'h0000 : {oam[ppu_hi], oam[ppu_lo]});
        // Stage 1: commit; a pending DMA write implies busy, so the CPU path cannot collide
        if (vld_p0)
            oam[a_p0] <= d_p0;
        else if (cpu_wr_ok)
            oam[cpu_a] <= cpu_d_in;
    end

`ifdef OAM_DMA_SEQ_CHECK_EN
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset)
            seq_err <= 1'b0;
        else
            seq_err <= (stb_ok & (dma_a != cnt_eff)) | (seq_err & ~run_rise);
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_oam_dma_sink.sv
// Directed bench for oam_dma_sink: transfer, blocking, range/abort/reset edge cases, sequence flag.
module tb_oam_dma_sink;
    logic        clk1 = 1'b0;
    logic        reset;
    logic        dma_run;
    logic        dma_wr_stb;
    logic [7:0]  dma_a;
    logic [7:0]  dma_d;
    logic        cpu_oam_sel;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_a;
    logic [7:0]  cpu_d_in;
    logic [7:0]  cpu_d_out;
    logic        ppu_rd;
    logic [7:0]  ppu_a;
    logic [15:0] ppu_d;
    logic        dma_done;
    logic [7:0]  byte_cnt;
    logic        addr_err;
    logic        seq_err;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt;
    logic [7:0]  rd8;
    logic [15:0] rd16;

`ifdef OAM_DMA_SEQ_CHECK_EN
    localparam logic SEQ_EXP = 1'b1;
`else
    localparam logic SEQ_EXP = 1'b0;
`endif

    oam_dma_sink dut (
        .clk1(clk1), .reset(reset), .dma_run(dma_run), .dma_wr_stb(dma_wr_stb),
        .dma_a(dma_a), .dma_d(dma_d), .cpu_oam_sel(cpu_oam_sel), .cpu_rd(cpu_rd),
        .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out),
        .ppu_rd(ppu_rd), .ppu_a(ppu_a), .ppu_d(ppu_d), .dma_done(dma_done),
        .byte_cnt(byte_cnt), .addr_err(addr_err), .seq_err(seq_err)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    task automatic strobe(input logic [7:0] a, input logic [7:0] d);
        dma_wr_stb = 1'b1;
        dma_a      = a;
        dma_d      = d;
        tick();
        dma_wr_stb = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        cpu_oam_sel = 1'b1;
        cpu_rd      = 1'b1;
        cpu_a       = a;
        tick();
        cpu_oam_sel = 1'b0;
        cpu_rd      = 1'b0;
        tick();
        d = cpu_d_out;
    endtask

    task automatic ppu_read(input logic [7:0] a, output logic [15:0] d);
        ppu_rd = 1'b1;
        ppu_a  = a;
        tick();
        ppu_rd = 1'b0;
        tick();
        d = ppu_d;
    endtask

    initial begin
        reset = 1'b1;
        dma_run = 1'b0; dma_wr_stb = 1'b0; dma_a = 8'h00; dma_d = 8'h00;
        cpu_oam_sel = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = 8'h00; cpu_d_in = 8'h00;
        ppu_rd = 1'b0; ppu_a = 8'h00;
        tick(); tick();
        chk("rst_cpu_d_out", 16'(cpu_d_out), 16'h00FF);
        chk("rst_ppu_d", ppu_d, 16'hFFFF);
        chk("rst_done", 16'(dma_done), 16'h0);
        chk("rst_byte_cnt", 16'(byte_cnt), 16'h0);
        chk("rst_addr_err", 16'(addr_err), 16'h0);
        chk("rst_seq_err", 16'(seq_err), 16'h0);
        reset = 1'b0;
        tick();

        // full transfer
        dma_run = 1'b1;
        tick();
        done_cnt = 0;
        for (int i = 0; i < 160; i++) begin
            strobe(8'(i), 8'(i) ^ 8'h5A);
            done_cnt += int'(dma_done);
        end
        tick();
        chk("full_done_pulse", 16'(dma_done), 16'h1);
        chk("full_byte_cnt", 16'(byte_cnt), 16'd160);
        chk("full_no_early_done", 16'(done_cnt), 16'h0);
        tick();
        chk("full_done_single", 16'(dma_done), 16'h0);

        // blocking and overflow while run stays high
        strobe(8'h00, 8'h99);
        tick();
        chk("over_addr_err", 16'(addr_err), 16'h1);
        chk("over_byte_cnt", 16'(byte_cnt), 16'd160);
        cpu_oam_sel = 1'b1; cpu_wr = 1'b1; cpu_a = 8'h05; cpu_d_in = 8'h33;
        tick();
        cpu_oam_sel = 1'b0; cpu_wr = 1'b0;
        cpu_read(8'h05, rd8);
        chk("blk_cpu_rd", 16'(rd8), 16'h00FF);
        ppu_read(8'h04, rd16);
        chk("blk_ppu_rd", rd16, 16'hFFFF);
        dma_run = 1'b0;
        tick();
        cpu_read(8'h00, rd8);
        chk("full_idx00", 16'(rd8), 16'h005A);
        cpu_read(8'h9F, rd8);
        chk("full_idx9f", 16'(rd8), 16'h00C5);
        cpu_read(8'h05, rd8);
        chk("blk_idx05_kept", 16'(rd8), 16'h005F);
        ppu_read(8'h05, rd16);
        chk("idle_ppu_pair", rd16, 16'h5F5E);

        // range error
        dma_run = 1'b1;
        tick();
        strobe(8'h00, 8'h5A);
        strobe(8'hA3, 8'h77);
        tick();
        chk("rng_addr_err", 16'(addr_err), 16'h1);
        chk("rng_byte_cnt", 16'(byte_cnt), 16'h1);
        dma_run = 1'b0;
        tick();
        dma_run = 1'b1;
        tick();
        chk("rng_clear_err", 16'(addr_err), 16'h0);
        chk("rng_clear_cnt", 16'(byte_cnt), 16'h0);

        // strobe coincident with run rise
        dma_run = 1'b0;
        tick();
        dma_run = 1'b1;
        strobe(8'h00, 8'h5A);
        tick();
        chk("coin_byte_cnt", 16'(byte_cnt), 16'h1);

        // abort after 40 bytes
        dma_run = 1'b0;
        tick();
        dma_run = 1'b1;
        tick();
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            strobe(8'(i), 8'(i) ^ 8'hA5);
            done_cnt += int'(dma_done);
        end
        dma_run = 1'b0;
        tick();
        chk("abort_byte_cnt", 16'(byte_cnt), 16'd40);
        for (int i = 0; i < 3; i++) begin
            tick();
            done_cnt += int'(dma_done);
        end
        chk("abort_cnt_frozen", 16'(byte_cnt), 16'd40);
        chk("abort_no_done", 16'(done_cnt), 16'h0);
        cpu_read(8'd39, rd8);
        chk("abort_idx39", 16'(rd8), 16'h0082);
        cpu_read(8'd40, rd8);
        chk("abort_idx40_old", 16'(rd8), 16'h0072);

        // idle CPU write with simultaneous PPU read
        cpu_oam_sel = 1'b1; cpu_wr = 1'b1; cpu_a = 8'h06; cpu_d_in = 8'h33;
        ppu_rd = 1'b1; ppu_a = 8'h06;
        tick();
        cpu_oam_sel = 1'b0; cpu_wr = 1'b0; ppu_rd = 1'b0;
        tick();
        chk("idle_ppu_prewrite", ppu_d, 16'hA2A3);
        cpu_read(8'h06, rd8);
        chk("idle_cpu_wr", 16'(rd8), 16'h0033);
        cpu_read(8'hA5, rd8);
        chk("idle_cpu_oor", 16'(rd8), 16'h0000);

        // sequence check
        dma_run = 1'b1;
        tick();
        strobe(8'h00, 8'h11);
        strobe(8'h01, 8'h11);
        strobe(8'h03, 8'h11);
        tick();
        chk("seq_byte_cnt", 16'(byte_cnt), 16'h3);
        chk("seq_err", 16'(seq_err), 16'(SEQ_EXP));

        // reset with a write pending
        dma_run = 1'b0;
        tick();
        dma_run = 1'b1;
        tick();
        strobe(8'h0A, 8'hEE);
        reset = 1'b1;
        dma_run = 1'b0;
        #1;
        chk("rstp_cpu_d_out", 16'(cpu_d_out), 16'h00FF);
        chk("rstp_byte_cnt", 16'(byte_cnt), 16'h0);
        #1;
        reset = 1'b0;
        tick();
        cpu_read(8'h0A, rd8);
        chk("rstp_idx0a_kept", 16'(rd8), 16'h00AF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
